game_flow_ctrl: RTL and testbench

//  Top-level game sequencer. Sits downstream of the debounced one-shot button pulses.

---
 rtl/game_flow_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE -> COUNTDOWN -> PLAY -> OVER, with lane, score, lives and invulnerability.
// Optional PAUSE state when GAME_PAUSE_EN is defined (i_start toggles PLAY <-> PAUSE).
module game_flow_ctrl #(
  parameter int COUNT_FROM   = 3,
  parameter int COUNTDOWN_MS = 1000,
  parameter int LIVES        = 3,
  parameter int SCORE_MS     = 100,
  parameter int SCORE_MAX    = 9999,
  parameter int INVULN_MS    = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_restart,
  input  logic [1:0]  i_play,
  input  logic        i_collide,
  output logic [2:0]  o_state,
  output logic [1:0]  o_countdown,
  output logic        o_lane,
  output logic [13:0] o_score,
  output logic [1:0]  o_lives,
  output logic        o_run,
  output logic        o_clear,
  output logic        o_hit
);

  localparam int MS_MAX = (COUNTDOWN_MS > SCORE_MS) ? COUNTDOWN_MS : SCORE_MS;
  localparam int MW     = $clog2(MS_MAX + 1);
  localparam int IW     = $clog2(INVULN_MS + 1);

  localparam logic [MW-1:0] CD_LAST   = MW'(COUNTDOWN_MS - 1);
  localparam logic [MW-1:0] SC_LAST   = MW'(SCORE_MS - 1);
  localparam logic [IW-1:0] INV_LOAD  = IW'(INVULN_MS);
  localparam logic [13:0]   SCORE_TOP = 14'(SCORE_MAX);
  localparam logic [1:0]    LIVES_LD  = 2'(LIVES);
  localparam logic [1:0]    DIGIT_LD  = 2'(COUNT_FROM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CD    = 3'd1,
    S_PLAY  = 3'd2,
    S_OVER  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] invuln_q, invuln_d;
  logic [1:0]    digit_q, digit_d;
  logic          lane_q, lane_d;
  logic [13:0]   score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic          clear_q, clear_d;
  logic          hit_q, hit_d;
  logic          new_game;
  logic          pause_req;

`ifdef GAME_PAUSE_EN
  assign pause_req = i_start;
`else
  assign pause_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      invuln_q <= '0;
      digit_q  <= 2'd0;
      lane_q   <= 1'b0;
      score_q  <= 14'd0;
      lives_q  <= LIVES_LD;
      clear_q  <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      invuln_q <= invuln_d;
      digit_q  <= digit_d;
      lane_q   <= lane_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      clear_q  <= clear_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    invuln_d = invuln_q;
    digit_d  = digit_q;
    lane_d   = lane_q;
    score_d  = score_q;
    lives_d  = lives_q;
    clear_d  = 1'b0;
    hit_d    = 1'b0;
    new_game = (i_restart && state_q != S_IDLE) ||
               (i_start && (state_q == S_IDLE || state_q == S_OVER));

    if (new_game) begin
      state_d  = S_CD;
      cnt_d    = '0;
      invuln_d = '0;
      digit_d  = DIGIT_LD;
      lane_d   = 1'b0;
      score_d  = 14'd0;
      lives_d  = LIVES_LD;
      clear_d  = 1'b1;
    end else begin
      case (state_q)
        S_CD: begin
          if (i_tick) begin
            if (cnt_q == CD_LAST) begin
              cnt_d = '0;
              if (digit_q == 2'd1) begin
                state_d = S_PLAY;
                digit_d = 2'd0;
              end else begin
                digit_d = digit_q - 2'd1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (pause_req) begin
            state_d = S_PAUSE;
          end else begin
            if (i_tick) begin
              if (cnt_q == SC_LAST) begin
                cnt_d = '0;
                if (score_q != SCORE_TOP) score_d = score_q + 14'd1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            // An accepted hit reloads the timer; a dropped one still lets the timer run down.
            if (i_collide && invuln_q == '0) begin
              hit_d    = 1'b1;
              invuln_d = INV_LOAD;
              lives_d  = lives_q - 2'd1;
              if (lives_q == 2'd1) state_d = S_OVER;
            end else if (i_tick && invuln_q != '0) begin
              invuln_d = invuln_q - 1'b1;
            end
            if (state_d == S_PLAY) begin
              if (i_play == 2'b01)      lane_d = 1'b0;
              else if (i_play == 2'b10) lane_d = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (pause_req) state_d = S_PLAY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_state     = state_q;
    o_countdown = digit_q;
    o_lane      = lane_q;
    o_score     = score_q;
    o_lives     = lives_q;
    o_run       = (state_q == S_PLAY);
    o_clear     = clear_q;
    o_hit       = hit_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timing constants; covers the GAME_PAUSE_EN build too.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tick, i_start, i_restart, i_collide;
  logic [1:0]  i_play;
  logic [2:0]  o_state;
  logic [1:0]  o_countdown, o_lives;
  logic        o_lane, o_run, o_clear, o_hit;
  logic [13:0] o_score;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .COUNT_FROM(3), .COUNTDOWN_MS(4), .LIVES(3),
    .SCORE_MS(2), .SCORE_MAX(9999), .INVULN_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start),
    .i_restart(i_restart), .i_play(i_play), .i_collide(i_collide),
    .o_state(o_state), .o_countdown(o_countdown), .o_lane(o_lane),
    .o_score(o_score), .o_lives(o_lives), .o_run(o_run),
    .o_clear(o_clear), .o_hit(o_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic tk, input logic st, input logic rs,
                      input logic [1:0] pl, input logic co);
    i_tick = tk; i_start = st; i_restart = rs; i_play = pl; i_collide = co;
    @(posedge clk);
    #1;
    i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0; i_play = 2'b00; i_collide = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0; i_play = 2'b00; i_collide = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", o_state, 0);
    check("rst_lives", o_lives, 3);
    check("rst_score", o_score, 0);
    check("rst_clear", o_clear, 0);
    check("rst_cd", o_countdown, 0);
    check("rst_lane", o_lane, 0);
    check("rst_run", o_run, 0);
    check("rst_hit", o_hit, 0);
    rst = 1'b1;

    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    check("idle_restart_state", o_state, 0);
    check("idle_restart_clear", o_clear, 0);
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("idle_play_lane", o_lane, 0);

    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("start_state", o_state, 1);
    check("start_cd", o_countdown, 3);
    check("start_clear", o_clear, 1);
    check("start_run", o_run, 0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("clear_pulse", o_clear, 0);
    ticks(3);
    check("cd_hold3", o_countdown, 3);
    ticks(1);
    check("cd_digit2", o_countdown, 2);
    ticks(7);
    check("cd_digit1", o_countdown, 1);
    check("cd_state", o_state, 1);
    ticks(1);
    check("play_state", o_state, 2);
    check("play_run", o_run, 1);
    check("play_cd0", o_countdown, 0);

    ticks(10);
    check("score5", o_score, 5);

`ifdef GAME_PAUSE_EN
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("pause_state", o_state, 4);
    check("pause_run", o_run, 0);
    ticks(20);
    check("pause_score", o_score, 5);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("pause_collide", o_lives, 3);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("resume_state", o_state, 2);
    ticks(2);
    check("resume_score", o_score, 6);
    ticks(2);
`else
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("start_in_play", o_state, 2);
    ticks(4);
    check("score7", o_score, 7);
`endif

    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    check("lane_down", o_lane, 1);
    step(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
    check("lane_both", o_lane, 1);
    step(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    check("lane_up", o_lane, 0);

    // Score is 7 with ms counter 0 in both builds from here on.
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("hit1_lives", o_lives, 2);
    check("hit1_pulse", o_hit, 1);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("hit1_pulse_end", o_hit, 0);
    ticks(1);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("invuln_lives", o_lives, 2);
    check("invuln_nohit", o_hit, 0);
    ticks(3);
    check("score9", o_score, 9);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    check("hit2_lives", o_lives, 1);
    check("hit2_pulse", o_hit, 1);
    ticks(3);
    check("score10", o_score, 10);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    check("over_state", o_state, 3);
    check("over_run", o_run, 0);
    check("over_lives", o_lives, 0);
    check("over_hit", o_hit, 1);
    check("over_score_same_cycle", o_score, 11);
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
    check("over_lane", o_lane, 0);
    check("over_collide", o_hit, 0);
    ticks(6);
    check("over_frozen", o_score, 11);

    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("restart_over_state", o_state, 1);
    check("restart_over_score", o_score, 0);
    check("restart_over_lives", o_lives, 3);
    check("restart_over_clear", o_clear, 1);
    ticks(3);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    check("start_in_cd", o_countdown, 3);
    check("start_in_cd_clear", o_clear, 0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    check("restart_cd_clear", o_clear, 1);
    ticks(3);
    check("restart_cd_cnt", o_countdown, 3);
    ticks(9);
    check("play2_state", o_state, 2);
    ticks(4);
    step(1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
    check("play2_lives", o_lives, 2);
    check("play2_lane", o_lane, 1);
    check("play2_score", o_score, 2);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    check("restart_play_state", o_state, 1);
    check("restart_play_score", o_score, 0);
    check("restart_play_lives", o_lives, 3);
    check("restart_play_lane", o_lane, 0);
    check("restart_play_run", o_run, 0);

    ticks(12);
    check("play3_state", o_state, 2);
    ticks(20000);
    check("score_sat", o_score, 9999);
    ticks(4);
    check("score_sat_hold", o_score, 9999);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
